teng_rx_block_sync: RTL
=======================

// Module: teng_rx_block_sync
// PURPOSE
// - Per-lane 64b/66b block-lock and BER monitor for the 10G RX path. Sits between the
//   rx gearboxes and the rx MAC/decoder; one lane per GT lane.
// - Runs a Clause-49 style lock FSM that drives gearbox slip until sync headers align.
// - Adds a hi-BER monitor and saturating sync-header error counters, which the current rx path lacks.
// PARAMETERS
// - NUMBER_OF_LANES  2     lane count; all per-lane buses are packed, lane i at [i*W +: W]
// - SH_WINDOW        64    sync headers per test window
// - INVLD_MAX        16    invalid headers in one window that drop lock
// - SLIP_WAIT        32    clk cycles headers are ignored after a slip (gearbox settle)
// - BER_WINDOW       20000 clk cycles per hi-BER window (125 us class)
// - BER_THRESH       16    invalid headers in one BER window that set hi_ber
// - CNT_W            16    width of each error counter
// PORTS
// - clk_i           in   1           rx user clock
// - rst_n_i         in   1           async active-low reset
// - head_i          in   NL*2        sync header per lane; valid headers are 2'b01 and 2'b10
// - head_valid_i    in   NL          head_i sample strobe per lane (gearbox cadence, may gap)
// - slip_o          out  NL          1-cycle slip pulse to the lane's gearbox
// - block_lock_o    out  NL          lane aligned
// - hi_ber_o        out  NL          lane high bit-error rate
// - all_lock_o      out  1           &block_lock_o (combinational from registers)
// - err_cnt_o       out  NL*CNT_W    saturating invalid-header count while locked
// - err_cnt_clr_i   in   1           synchronous clear of all error counters
// BEHAVIOUR
// - Reset: every output 0; FSM in LOCK_INIT; all counters 0. Async assert, sync release via rst_n_i.
// - FSM per lane: LOCK_INIT -> RESET_CNT -> TEST_SH -> {RESET_CNT, SLIP}; SLIP -> WAIT -> RESET_CNT.
// - RESET_CNT (1 cycle): sh_cnt = 0, sh_invld = 0.
// - TEST_SH: on head_valid_i, sh_cnt++ and, if the header is invalid, sh_invld++.
// - TEST_SH, unlocked: any invalid header -> SLIP. sh_cnt reaching SH_WINDOW with sh_invld = 0
//   -> block_lock = 1, RESET_CNT.
// - TEST_SH, locked: sh_invld reaching INVLD_MAX -> block_lock = 0, SLIP.
//   Otherwise sh_cnt reaching SH_WINDOW -> RESET_CNT.
// - SLIP: slip_o = 1 for exactly one cycle and block_lock = 0. WAIT then counts SLIP_WAIT cycles.
//   head_valid_i is ignored in SLIP and WAIT.
// - Latency: slip_o and the block_lock rise are registered, one cycle after the deciding
//   head_valid_i sample.
// - hi-BER: active only while locked. The window counter wraps every BER_WINDOW cycles; the
//   invalid count saturates at BER_THRESH.
//   - Reaching BER_THRESH sets hi_ber immediately.
//   - At window end, hi_ber = (count >= BER_THRESH), then count = 0.
//   - Loss of lock clears hi_ber, the window counter and the count.
// - err_cnt: +1 per invalid header sampled while locked; saturates at 2^CNT_W-1 and does not wrap.
//   err_cnt_clr_i has priority; a coincident error is dropped (result 0).
// - Lanes are fully independent; no cross-lane state except all_lock_o.
// - Reset mid-operation: all state returns to reset values asynchronously. Any in-flight
//   slip pulse is cut.
// STRUCTURE
// - Package teng_pcs_pkg:
//   - SH_DATA = 2'b01, SH_CTRL = 2'b10.
//   - lock FSM state enum {LOCK_INIT, RESET_CNT, TEST_SH, SLIP, WAIT}.
//   - function sh_is_valid().
// - Sub-module teng_block_lock_lane holds one lane's FSM, hi-BER monitor and err counter.
//   The top level is a generate loop over NUMBER_OF_LANES plus the all_lock_o AND.
// TESTING (NL=2, SH_WINDOW=64, INVLD_MAX=16, SLIP_WAIT=32, BER_WINDOW=2000, BER_THRESH=16)
// - Lock acquire: after reset, 64 headers of 2'b01 with head_valid every 2nd cycle.
//   block_lock_o[0] rises 1 cycle after the 64th sample; slip_o stays 0; all_lock_o rises
//   when both lanes lock.
// - Slip while unlocked: head 2'b00 at the 10th sample.
//   - slip_o[0] is a single 1-cycle pulse, and the 32 cycles that follow ignore headers.
//   - Lock comes 64 clean samples later.
// - Lock loss while locked: 15 invalid headers in one 64-window keep block_lock = 1 and
//   err_cnt = 15. 16 invalid headers drop lock and pulse slip_o, with err_cnt = 16;
//   lane 1 is unaffected and all_lock_o = 0.
// - hi-BER: 8 invalid per 64-window (lock held) hits 16 within 2000 cycles and hi_ber_o = 1.
//   The next window with 0 errors gives hi_ber_o = 0 at window end.
// - Counter edges:
//   - CNT_W=4 with 20 errors holds err_cnt at 15.
//   - err_cnt_clr_i coincident with an error gives 0.
//   - head 2'b11 counts as invalid.
// - Async reset: rst_n_i low mid TEST_SH and mid-slip forces all outputs to 0 within the cycle.
//   Relock takes exactly 64 clean samples.

Source files
------------

// File: rtl/teng_pcs_pkg.sv
// Shared 64b/66b PCS definitions: sync-header codes, lock FSM states and header checks.
package teng_pcs_pkg;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    typedef enum logic [2:0] {
        LOCK_INIT = 3'd0,
        RESET_CNT = 3'd1,
        TEST_SH   = 3'd2,
        SLIP      = 3'd3,
        WAIT      = 3'd4
    } lock_state_e;

    // Only the two mixed-bit codes are legal; 2'b00 and 2'b11 are bit errors.
    function automatic logic sh_is_valid(input logic [1:0] sh);
        return (sh == SH_DATA) || (sh == SH_CTRL);
    endfunction

endpackage

// File: rtl/teng_rx_block_sync_if.sv
// Bus between the rx gearboxes / MAC side and the per-lane block-lock monitor.
interface teng_rx_block_sync_if #(
    parameter int NUMBER_OF_LANES = 2,
    parameter int CNT_W           = 16
);
    logic [NUMBER_OF_LANES*2-1:0]     head_i;
    logic [NUMBER_OF_LANES-1:0]       head_valid_i;
    logic                             err_cnt_clr_i;
    logic [NUMBER_OF_LANES-1:0]       slip_o;
    logic [NUMBER_OF_LANES-1:0]       block_lock_o;
    logic [NUMBER_OF_LANES-1:0]       hi_ber_o;
    logic                             all_lock_o;
    logic [NUMBER_OF_LANES*CNT_W-1:0] err_cnt_o;

    modport master (
        output head_i, head_valid_i, err_cnt_clr_i,
        input  slip_o, block_lock_o, hi_ber_o, all_lock_o, err_cnt_o
    );

    modport slave (
        input  head_i, head_valid_i, err_cnt_clr_i,
        output slip_o, block_lock_o, hi_ber_o, all_lock_o, err_cnt_o
    );
endinterface

// File: rtl/teng_block_lock_lane.sv
// One 64b/66b lane: block-lock FSM driving gearbox slip, hi-BER monitor and
// saturating sync-header error counter.
module teng_block_lock_lane #(
    parameter int SH_WINDOW  = 64,
    parameter int INVLD_MAX  = 16,
    parameter int SLIP_WAIT  = 32,
    parameter int BER_WINDOW = 20000,
    parameter int BER_THRESH = 16,
    parameter int CNT_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [1:0]       i_head,
    input  logic             i_head_valid,
    input  logic             i_err_cnt_clr,
    output logic             o_slip,
    output logic             o_block_lock,
    output logic             o_hi_ber,
    output logic [CNT_W-1:0] o_err_cnt
);
    import teng_pcs_pkg::*;

    localparam int SH_CW = $clog2(SH_WINDOW + 1);
    localparam int IV_W  = $clog2(INVLD_MAX + 1);
    localparam int WT_W  = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;
    localparam int BW_W  = (BER_WINDOW > 1) ? $clog2(BER_WINDOW) : 1;
    localparam int BC_W  = $clog2(BER_THRESH + 1);

    localparam logic [SH_CW-1:0] SH_WINDOW_C    = SH_CW'(SH_WINDOW);
    localparam logic [IV_W-1:0]  INVLD_MAX_C    = IV_W'(INVLD_MAX);
    localparam logic [WT_W-1:0]  WAIT_LAST_C    = WT_W'(SLIP_WAIT - 1);
    localparam logic [BW_W-1:0]  BER_WIN_LAST_C = BW_W'(BER_WINDOW - 1);
    localparam logic [BC_W-1:0]  BER_THRESH_C   = BC_W'(BER_THRESH);
    localparam logic [CNT_W-1:0] ERR_MAX_C      = {CNT_W{1'b1}};

    lock_state_e      r_state;
    logic [SH_CW-1:0] r_sh_cnt;
    logic [IV_W-1:0]  r_sh_invld;
    logic [WT_W-1:0]  r_wait_cnt;
    logic             r_block_lock;
    logic             r_slip;
    logic [BW_W-1:0]  r_ber_win;
    logic [BC_W-1:0]  r_ber_cnt;
    logic             r_hi_ber;
    logic [CNT_W-1:0] r_err_cnt;

    logic             w_sample;
    logic             w_invalid;
    logic [SH_CW-1:0] w_cnt_nxt;
    logic [IV_W-1:0]  w_invld_nxt;
    logic             w_bad_locked;
    logic             w_lock_drop;
    logic [BC_W-1:0]  w_ber_cnt_nxt;

    // Headers only count while testing; SLIP/WAIT/RESET_CNT discard them.
    always_comb begin
        w_sample    = 1'b0;
        w_invalid   = 1'b0;
        w_cnt_nxt   = r_sh_cnt;
        w_invld_nxt = r_sh_invld;
        if ((r_state == TEST_SH) && i_head_valid) begin
            w_sample    = 1'b1;
            w_invalid   = ~sh_is_valid(i_head);
            w_cnt_nxt   = r_sh_cnt + SH_CW'(1);
            w_invld_nxt = r_sh_invld + IV_W'(w_invalid);
        end else begin
            w_sample    = 1'b0;
        end
    end

    assign w_bad_locked = w_sample & w_invalid & r_block_lock;
    assign w_lock_drop  = w_sample & r_block_lock & (w_invld_nxt == INVLD_MAX_C);

    // Saturating hi-BER invalid count for the current cycle
    always_comb begin
        w_ber_cnt_nxt = r_ber_cnt;
        if (w_bad_locked && (r_ber_cnt != BER_THRESH_C)) begin
            w_ber_cnt_nxt = r_ber_cnt + BC_W'(1);
        end else begin
            w_ber_cnt_nxt = r_ber_cnt;
        end
    end

    // Block-lock FSM with registered slip pulse and lock flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= LOCK_INIT;
            r_sh_cnt     <= '0;
            r_sh_invld   <= '0;
            r_wait_cnt   <= '0;
            r_block_lock <= 1'b0;
            r_slip       <= 1'b0;
        end else begin
            r_slip <= 1'b0;
            case (r_state)
                LOCK_INIT: begin
                    r_block_lock <= 1'b0;
                    r_state      <= RESET_CNT;
                end
                RESET_CNT: begin
                    r_sh_cnt   <= '0;
                    r_sh_invld <= '0;
                    r_state    <= TEST_SH;
                end
                TEST_SH: begin
                    if (w_sample) begin
                        r_sh_cnt   <= w_cnt_nxt;
                        r_sh_invld <= w_invld_nxt;
                        if (!r_block_lock) begin
                            if (w_invalid) begin
                                r_slip  <= 1'b1;
                                r_state <= SLIP;
                            end else if (w_cnt_nxt == SH_WINDOW_C) begin
                                r_block_lock <= 1'b1;
                                r_state      <= RESET_CNT;
                            end else begin
                                r_state <= TEST_SH;
                            end
                        end else if (w_lock_drop) begin
                            r_block_lock <= 1'b0;
                            r_slip       <= 1'b1;
                            r_state      <= SLIP;
                        end else if (w_cnt_nxt == SH_WINDOW_C) begin
                            r_state <= RESET_CNT;
                        end else begin
                            r_state <= TEST_SH;
                        end
                    end else begin
                        r_state <= TEST_SH;
                    end
                end
                SLIP: begin
                    r_block_lock <= 1'b0;
                    r_wait_cnt   <= '0;
                    r_state      <= WAIT;
                end
                WAIT: begin
                    if (r_wait_cnt == WAIT_LAST_C) begin
                        r_state <= RESET_CNT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WT_W'(1);
                    end
                end
                default: begin
                    r_block_lock <= 1'b0;
                    r_state      <= LOCK_INIT;
                end
            endcase
        end
    end

    // hi-BER window: runs only while locked, restarts from zero on every lock
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ber_win <= '0;
            r_ber_cnt <= '0;
            r_hi_ber  <= 1'b0;
        end else if (!r_block_lock || w_lock_drop) begin
            r_ber_win <= '0;
            r_ber_cnt <= '0;
            r_hi_ber  <= 1'b0;
        end else if (r_ber_win == BER_WIN_LAST_C) begin
            r_ber_win <= '0;
            r_ber_cnt <= '0;
            r_hi_ber  <= (w_ber_cnt_nxt == BER_THRESH_C);
        end else begin
            r_ber_win <= r_ber_win + BW_W'(1);
            r_ber_cnt <= w_ber_cnt_nxt;
            r_hi_ber  <= r_hi_ber | (w_ber_cnt_nxt == BER_THRESH_C);
        end
    end

    // Error counter: clear wins over a same-cycle error
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_cnt <= '0;
        end else if (i_err_cnt_clr) begin
            r_err_cnt <= '0;
        end else if (w_bad_locked && (r_err_cnt != ERR_MAX_C)) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end else begin
            r_err_cnt <= r_err_cnt;
        end
    end

    assign o_slip       = r_slip;
    assign o_block_lock = r_block_lock;
    assign o_hi_ber     = r_hi_ber;
    assign o_err_cnt    = r_err_cnt;

endmodule

// File: rtl/teng_rx_block_sync.sv
// Per-lane 64b/66b block-lock and BER monitor for the 10G RX path; lanes are
// independent and only meet in all_lock_o.
module teng_rx_block_sync #(
    parameter int NUMBER_OF_LANES = 2,
    parameter int SH_WINDOW       = 64,
    parameter int INVLD_MAX       = 16,
    parameter int SLIP_WAIT       = 32,
    parameter int BER_WINDOW      = 20000,
    parameter int BER_THRESH      = 16,
    parameter int CNT_W           = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    teng_rx_block_sync_if.slave  bus
);
    logic [NUMBER_OF_LANES-1:0]       w_slip;
    logic [NUMBER_OF_LANES-1:0]       w_block_lock;
    logic [NUMBER_OF_LANES-1:0]       w_hi_ber;
    logic [NUMBER_OF_LANES*CNT_W-1:0] w_err_cnt;

    for (genvar g = 0; g < NUMBER_OF_LANES; g++) begin : g_lane
        teng_block_lock_lane #(
            .SH_WINDOW  (SH_WINDOW),
            .INVLD_MAX  (INVLD_MAX),
            .SLIP_WAIT  (SLIP_WAIT),
            .BER_WINDOW (BER_WINDOW),
            .BER_THRESH (BER_THRESH),
            .CNT_W      (CNT_W)
        ) u_lane (
            .i_clk         (clk_i),
            .i_rst_n       (rst_n_i),
            .i_head        (bus.head_i[g*2 +: 2]),
            .i_head_valid  (bus.head_valid_i[g]),
            .i_err_cnt_clr (bus.err_cnt_clr_i),
            .o_slip        (w_slip[g]),
            .o_block_lock  (w_block_lock[g]),
            .o_hi_ber      (w_hi_ber[g]),
            .o_err_cnt     (w_err_cnt[g*CNT_W +: CNT_W])
        );
    end

    assign bus.slip_o       = w_slip;
    assign bus.block_lock_o = w_block_lock;
    assign bus.hi_ber_o     = w_hi_ber;
    assign bus.err_cnt_o    = w_err_cnt;
    assign bus.all_lock_o   = &w_block_lock;

endmodule
